// File: rtl/sha_pkg.sv
// Shared constants and FSM state type for the SHA-256 message padder.
package sha_pkg;

    localparam int SHA_WORD_W = 32;
    localparam int SHA_BLK_W  = 512;

    localparam logic [7:0] SHA_PAD_BYTE = 8'h80;

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_PAD  = 2'd1,
        S_OUT  = 2'd2
    } sha_pad_state_t;

endpackage

// File: rtl/sha_pad_mask.sv
// Forms the final message word: keeps the first in_bytes bytes, places 0x80
// right after them and zeroes the remainder.
module sha_pad_mask
    import sha_pkg::*;
(
    input  logic [SHA_WORD_W-1:0] in_data,
    input  logic [2:0]            in_bytes,
    output logic [SHA_WORD_W-1:0] word,
    output logic                  pad_placed
);

    logic [2:0] nb;

    always_comb begin
        nb   = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
        word = '0;
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < nb) begin
                word[SHA_WORD_W-1-8*i -: 8] = in_data[SHA_WORD_W-1-8*i -: 8];
            end else if (3'(i) == nb) begin
                word[SHA_WORD_W-1-8*i -: 8] = SHA_PAD_BYTE;
            end
        end
        pad_placed = (nb != 3'd4);
    end

endmodule

// File: rtl/sha_pad.sv
// SHA-256 message padder / 512-bit block former with valid/ready on both sides.
// Optional macro SHA_PAD_STAT_EN adds the msg_cnt completed-message counter.
//
// state  | meaning
// S_FILL | accepting message words into the block buffer
// S_PAD  | writing 0x80 / zero fill / length words, one per cycle
// S_OUT  | block presented on out_block, waiting for out_ready
module sha_pad
    import sha_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SHA_WORD_W-1:0] in_data,
    input  logic                  in_last,
    input  logic [2:0]            in_bytes,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SHA_BLK_W-1:0]  out_block,
    output logic                  out_first,
    output logic                  out_last
`ifdef SHA_PAD_STAT_EN
    ,
    output logic [15:0]           msg_cnt
`endif
);

    sha_pad_state_t        state;
    logic [3:0]            ptr;
    logic [LEN_W-1:0]      len;
    logic                  pad_done;
    logic                  first;
    logic                  need2;
    logic [SHA_WORD_W-1:0] buf_q [16];

    logic [SHA_WORD_W-1:0] mask_word;
    logic                  pad_placed;
    logic [2:0]            last_bytes;
    logic [5:0]            len_inc;
    logic [63:0]           len64;
    logic [SHA_WORD_W-1:0] pad_word;

    sha_pad_mask u_mask (
        .in_data    (in_data),
        .in_bytes   (in_bytes),
        .word       (mask_word),
        .pad_placed (pad_placed)
    );

    assign out_first = first;

    always_comb begin
        last_bytes = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
        len_inc    = in_last ? {last_bytes, 3'b000} : 6'd32;
        len64      = 64'(len);
    end

    // Length words only go in a block whose 0x80 byte sits at word 13 or lower.
    always_comb begin
        pad_word = '0;
        if (!pad_done) begin
            pad_word = {SHA_PAD_BYTE, 24'h0};
        end else if (!need2 && ptr == 4'd14) begin
            pad_word = len64[63:32];
        end else if (!need2 && ptr == 4'd15) begin
            pad_word = len64[31:0];
        end
    end

    always_comb begin
        out_block = '0;
        for (int i = 0; i < 16; i++) begin
            out_block[SHA_BLK_W-1-SHA_WORD_W*i -: SHA_WORD_W] = buf_q[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_FILL;
            ptr       <= '0;
            len       <= '0;
            pad_done  <= 1'b0;
            first     <= 1'b1;
            need2     <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                buf_q[i] <= '0;
            end
`ifdef SHA_PAD_STAT_EN
            msg_cnt   <= '0;
`endif
        end else begin
            case (state)
                S_FILL: begin
                    if (in_valid) begin
                        buf_q[ptr] <= in_last ? mask_word : in_data;
                        len        <= len + LEN_W'(len_inc);
                        if (!in_last) begin
                            if (ptr == 4'd15) begin
                                state     <= S_OUT;
                                in_ready  <= 1'b0;
                                out_valid <= 1'b1;
                                out_last  <= 1'b0;
                            end else begin
                                ptr <= ptr + 4'd1;
                            end
                        end else begin
                            pad_done <= pad_placed;
                            if (ptr == 4'd15) begin
                                need2     <= 1'b1;
                                state     <= S_OUT;
                                in_ready  <= 1'b0;
                                out_valid <= 1'b1;
                                out_last  <= 1'b0;
                            end else begin
                                need2    <= pad_placed && (ptr == 4'd14);
                                ptr      <= ptr + 4'd1;
                                state    <= S_PAD;
                                in_ready <= 1'b0;
                            end
                        end
                    end
                end

                S_PAD: begin
                    buf_q[ptr] <= pad_word;
                    if (!pad_done) begin
                        pad_done <= 1'b1;
                        need2    <= (ptr >= 4'd14);
                    end
                    if (ptr == 4'd15) begin
                        state     <= S_OUT;
                        out_valid <= 1'b1;
                        out_last  <= pad_done && !need2;
                    end else begin
                        ptr <= ptr + 4'd1;
                    end
                end

                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        first     <= 1'b0;
                        ptr       <= '0;
`ifdef SHA_PAD_STAT_EN
                        if (out_last) begin
                            msg_cnt <= msg_cnt + 16'd1;
                        end
`endif
                        if (need2) begin
                            need2 <= 1'b0;
                            state <= S_PAD;
                        end else if (!pad_done) begin
                            state    <= S_FILL;
                            in_ready <= 1'b1;
                        end else begin
                            len      <= '0;
                            first    <= 1'b1;
                            pad_done <= 1'b0;
                            state    <= S_FILL;
                            in_ready <= 1'b1;
                        end
                    end
                end

                default: begin
                    state     <= S_FILL;
                    ptr       <= '0;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha_pad.sv
// Bench for sha_pad: directed latency/backpressure/reset steps plus random
// messages checked against a byte-level FIPS 180-4 padding model.
module tb_sha_pad;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_last;
    logic         out_ready;
    logic [31:0]  in_data;
    logic [2:0]   in_bytes;
    logic         in_ready;
    logic         out_valid;
    logic         out_first;
    logic         out_last;
    logic [511:0] out_block;
`ifdef SHA_PAD_STAT_EN
    logic [15:0]  msg_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int lasts_done = 0;

    byte unsigned msg_q[$];
    logic [511:0] exp_q[$];

    sha_pad dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_bytes  (in_bytes),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_block (out_block),
        .out_first (out_first),
        .out_last  (out_last)
`ifdef SHA_PAD_STAT_EN
        ,
        .msg_cnt   (msg_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_blk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%b want=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%0d want=%0d", tag, obs, exp);
        end
    endtask

    // Reference: append 0x80, zero to 56 mod 64, then the 64-bit bit length.
    function automatic void build_expected();
        byte unsigned     p[$];
        longint unsigned  bits;
        logic [511:0]     blk;
        p    = msg_q;
        bits = 64'(msg_q.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(8'(bits >> (8 * i)));
        exp_q.delete();
        for (int b = 0; b < p.size() / 64; b++) begin
            for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = p[64*b+j];
            exp_q.push_back(blk);
        end
    endfunction

    task automatic make_msg(input int n);
        msg_q.delete();
        for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom));
    endtask

    task automatic send_msg(input bit zero_tail);
        int          n, nbeats, idx, kept;
        bit          acc;
        logic [31:0] w;
        n = msg_q.size();
        if (n == 0 || (zero_tail && n % 4 == 0)) nbeats = n / 4 + 1;
        else nbeats = (n + 3) / 4;
        idx = 0;
        for (int bt = 0; bt < nbeats; bt++) begin
            kept = (bt == nbeats - 1) ? n - idx : 4;
            for (int j = 0; j < 4; j++)
                w[31-8*j -: 8] = (j < kept) ? msg_q[idx+j] : 8'($urandom);
            acc = 1'b0;
            for (int c = 0; c < 200 && !acc; c++) begin
                @(posedge clk); #1;
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = w;
                in_last  = (bt == nbeats - 1);
                if (!in_last) in_bytes = 3'($urandom);
                else if (kept == 4) in_bytes = 3'($urandom_range(4, 7));
                else in_bytes = 3'(kept);
                @(negedge clk);
                acc = in_valid && in_ready;
            end
            check_bit("beat_accept", acc, 1'b1);
            idx += kept;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic recv_blocks(input int prob_ready);
        int nblk;
        bit got;
        nblk = exp_q.size();
        for (int b = 0; b < nblk; b++) begin
            got = 1'b0;
            for (int c = 0; c < 200 && !got; c++) begin
                @(posedge clk); #1;
                out_ready = ($urandom_range(0, 99) < prob_ready);
                @(negedge clk);
                got = out_valid && out_ready;
            end
            check_bit("blk_seen", got, 1'b1);
            check_blk($sformatf("blk%0d_of_%0d_data", b, nblk), out_block, exp_q[b]);
            check_bit("blk_first", out_first, b == 0);
            check_bit("blk_last", out_last, b == nblk - 1);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run_msg(input int n, input bit zero_tail);
        make_msg(n);
        build_expected();
        fork
            send_msg(zero_tail);
            recv_blocks(70);
        join
        lasts_done++;
    endtask

    initial begin
        logic [511:0] abc_exp;
        int           lat;
        bit           stable, rdy_low, vld_seen;

        reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
        in_bytes = '0; out_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        check_bit("rst_out_valid", out_valid, 1'b0);
        check_bit("rst_out_first", out_first, 1'b1);
        check_bit("rst_out_last", out_last, 1'b0);
        check_blk("rst_out_block", out_block, '0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check_bit("rst_in_ready", in_ready, 1'b1);

        // "abc": latency, backpressure stability, then handshake
        abc_exp = '0;
        abc_exp[511:480] = 32'h61626380;
        abc_exp[31:0]    = 32'h00000018;
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 32'h61626300; in_bytes = 3'd3; in_last = 1'b1;
        @(negedge clk);
        check_bit("abc_accept", in_ready, 1'b1);
        @(posedge clk); #1 in_valid = 1'b0;
        lat = 0; rdy_low = 1'b1;
        for (int c = 0; c < 40 && !out_valid; c++) begin
            @(negedge clk);
            lat++;
            if (in_ready) rdy_low = 1'b0;
        end
        check_int("abc_latency", lat, 16);
        check_bit("pad_in_ready_low", rdy_low, 1'b1);
        stable = 1'b1; rdy_low = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (out_block !== abc_exp || !out_valid) stable = 1'b0;
            if (in_ready) rdy_low = 1'b0;
        end
        check_bit("bp_stable", stable, 1'b1);
        check_bit("bp_in_ready_low", rdy_low, 1'b1);
        check_blk("abc_block", out_block, abc_exp);
        check_bit("abc_first", out_first, 1'b1);
        check_bit("abc_last", out_last, 1'b1);
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        @(negedge clk);
        check_bit("abc_after_valid", out_valid, 1'b0);
        check_bit("abc_after_ready", in_ready, 1'b1);
        lasts_done++;

        // Boundary message sizes
        run_msg(0, 1'b1);
        run_msg(3, 1'b0);
        run_msg(55, 1'b0);
        run_msg(56, 1'b0);
        run_msg(57, 1'b0);
        run_msg(60, 1'b1);
        run_msg(63, 1'b0);
        run_msg(64, 1'b0);
        run_msg(64, 1'b1);
        run_msg(65, 1'b0);
        run_msg(119, 1'b0);
        run_msg(120, 1'b0);

        // Reset while padding: nothing emitted, next message starts clean
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 32'hdeadbeef; in_bytes = 3'd2; in_last = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (5) @(negedge clk);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        check_bit("rst_pad_valid", out_valid, 1'b0);
        check_bit("rst_pad_first", out_first, 1'b1);
        lasts_done = 0;
        @(posedge clk); #1 reset = 1'b0;
        vld_seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) vld_seen = 1'b1;
        end
        check_bit("rst_pad_no_block", vld_seen, 1'b0);
        run_msg(20, 1'b0);

        // Reset mid-fill discards the partial block
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_data = $urandom; in_last = 1'b0; in_bytes = 3'd4;
        end
        @(posedge clk); #1 in_valid = 1'b0; reset = 1'b1;
        lasts_done = 0;
        @(posedge clk); #1 reset = 1'b0;
        run_msg(70, 1'b0);

        repeat (8) run_msg($urandom_range(0, 150), 1'($urandom_range(0, 1)));

`ifdef SHA_PAD_STAT_EN
        @(negedge clk);
        check_int("msg_cnt", int'(msg_cnt), lasts_done);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sha_pad.md
# sha_pad

Message padder and block former that feeds the SHA-256 compression core. It accepts a byte-oriented message as a stream of 32-bit big-endian words and appends the FIPS 180-4 padding: a 0x80 byte, zero fill, and a 64-bit bit length. It emits complete 512-bit blocks over a valid/ready handshake. The block sits upstream of the core; the system controller drives `out_ready` when the core can take a new block, and the core consumes `out_block` as its `message`.

## Interface
- `LEN_W`, default 64: width of the bit-length counter (1..64). The length field is zero-extended to 64 bits. The counter wraps mod 2^LEN_W.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `in_valid` in 1: input word valid.
- `in_ready` out 1: padder accepts a word this cycle.
- `in_data` in 32: message word; first byte in [31:24].
- `in_last` in 1: final beat of the message.
- `in_bytes` in 3: valid bytes on a last beat (0..4), MSB-justified. Ignored (treated as 4) when `in_last`=0. Values 5..7 are treated as 4. A value of 0 means `in_data` is ignored, which allows an empty message.
- `out_valid` out 1: block available.
- `out_ready` in 1: downstream accepts the block.
- `out_block` out 512: block; word 0 is in [511:480].
- `out_first` out 1: block is the first block of its message.
- `out_last` out 1: block is the final block of its message (contains the length field).

## Operation
- Internal state:
  - 16×32 block buffer.
  - 4-bit word pointer `ptr`.
  - LEN_W byte-derived bit counter `len`.
  - Flags `pad_done` (0x80 placed), `first`, and `need2` (second block required).
- FSM states are S_FILL, S_PAD and S_OUT.
- S_FILL:
  - `in_ready`=1.
  - A non-last beat writes `buf[ptr]`, increments `ptr` and adds 32 to `len`.
  - A last beat with b bytes writes the kept bytes and zeroes the rest. If b<4, 0x80 goes at byte position b and `pad_done` is set. `len` is increased by 8·b.
  - If a full (non-last) beat lands at `ptr`=15, go to S_OUT.
  - If a last beat lands at `ptr`=15 and b=4, go to S_OUT with `need2`=1.
  - If a last beat lands at `ptr`=15 and b<4, `need2`=1 because no length space remains; go to S_OUT.
  - Any other last beat goes to S_PAD with `ptr`+1.
- S_PAD writes one word per cycle at `ptr`:
  - 32'h80000000 if `pad_done`=0, then set `pad_done`.
  - Otherwise zero, except `len` high word at `ptr`=14 and low word at `ptr`=15. This applies only if the 0x80 byte was placed at index ≤13 of this block.
  - If the 0x80 byte lands at index 14 or 15, words up to 15 are zero, `need2`=1, and the length goes in the next block.
  - When `ptr`=15 is written, go to S_OUT.
- S_OUT:
  - `out_valid`=1; `out_block`, `out_first` and `out_last` are stable.
  - On `out_ready`, clear `first`.
  - If `need2`, clear it, set `ptr`=0 and go to S_PAD (second block: zeros, then length).
  - If the block held only message data (`in_last` not yet seen), set `ptr`=0 and go to S_FILL.
  - Otherwise (message complete), clear `len`, set `first`=1 and `ptr`=0, and go to S_FILL.
- `out_last` is 1 only on the block that carries the length.

## Timing
- Reset values:
  - state S_FILL; `in_ready`=1 after reset deasserts.
  - `out_valid`=0, `out_first`=1, `out_last`=0, `out_block`=0.
  - `ptr`=0, `len`=0.
- Reset asserted mid-message discards all partial state. No block is emitted.
- Input throughput is one word per cycle in S_FILL. `in_ready`=0 in S_PAD and S_OUT, and `in_valid` is ignored there.
- Latency: if the last beat at index k is accepted in cycle t, `out_valid` rises in cycle t+1+(15−k) for a single-block finish (at t+1 when k=15).
- `out_valid` holds with the block stable until `out_ready` is high. `out_ready` without `out_valid` is ignored.
- The cycle after the handshake is in S_FILL (`in_ready`=1) or S_PAD. There are no bubbles beyond that single cycle.

## Configuration
- Macro `SHA_PAD_STAT_EN`, when defined:
  - Adds output `msg_cnt` out 16, the number of messages whose `out_last` block was accepted.
  - Increments on the handshake of an `out_last` block, wraps at 2^16, and resets to 0.
- Without the macro, the port and counter are absent. Behaviour is otherwise identical.

## Structure
- Package `sha_pkg` holds:
  - `SHA_WORD_W`=32 and `SHA_BLK_W`=512.
  - `SHA_PAD_BYTE`=8'h80.
  - The FSM state enum `sha_pad_state_t`.
- One sub-module, `sha_pad_mask`: a combinational last-word former taking (`in_data`, `in_bytes`) and producing the masked word with 0x80 inserted and a `pad_placed` flag.

## Test plan
- "abc": `in_data`=0x61626300, `in_bytes`=3, `in_last` at index 0. Expect `out_valid` 16 cycles later with `out_block` word0=0x61626380, words1..14=0, word15=0x00000018, and `out_first`=`out_last`=1. Optionally, through the core, the hash is ba7816bf…f20015ad.
- Empty message: one beat with `in_bytes`=0 and `in_last`. Expect word0=0x80000000, all other words 0, length 0, a single block.
- 56 bytes (14 full beats, the last with `in_bytes`=4). Expect two blocks:
  - Block 1: word14=0x80000000, word15=0, `out_last`=0.
  - Block 2: zeros, word15=0x000001C0, `out_first`=0, `out_last`=1.
- 64 bytes (16 full beats). Expect:
  - Block 1: raw data, `out_first`=1, `out_last`=0.
  - Block 2: word0=0x80000000, word15=0x00000200.
- Backpressure and reset:
  - Hold `out_ready`=0 for 20 cycles: `out_block` stays stable and `in_ready`=0.
  - Assert `reset` during S_PAD: `out_valid` stays 0 and the next message starts with `out_first`=1 and `len`=0.
